// File: rtl/timed_rr_arbiter.sv
// timed_rr_arbiter: round-robin arbiter granting a shared timed resource
// for T_MIN..T_MAX cycles, with a T_GAP-cycle idle gap after every grant.
module timed_rr_arbiter #(
  parameter int N = 4,
  parameter int T_MIN = 2,
  parameter int T_MAX = 4,
  parameter int T_GAP = 1,
  localparam int IW = (N > 2) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          busy,
  output logic          timeout
);
  localparam int CW = $clog2(T_MAX + 1);
  localparam int GW = $clog2(T_GAP + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic [2*N-1:0] rot;
  logic [IW-1:0] off, pick, nxt;
  logic [IW:0]   sum, sub;
  logic          any;

  // rotate the request vector so the search always starts at bit 0
  always_comb begin
    rot = {req, req} >> ptr;
    any = |req;
    off = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) off = IW'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    sub = sum - (IW+1)'(N);
    pick = (sum >= (IW+1)'(N)) ? sub[IW-1:0] : sum[IW-1:0];
    nxt = (pick == IW'(N - 1)) ? '0 : pick + IW'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      busy <= 1'b0;
      timeout <= 1'b0;
      ptr <= '0;
      cnt <= '0;
      gcnt <= '0;
    end else begin
      timeout <= 1'b0;
      if (state == GRANT) begin
        if (cnt == CW'(T_MAX)) begin
          state <= GAP;
          gnt <= '0;
          timeout <= 1'b1;
          gcnt <= GW'(1);
        end else if (cnt >= CW'(T_MIN) && !req[gnt_id]) begin
          state <= GAP;
          gnt <= '0;
          gcnt <= GW'(1);
        end else cnt <= cnt + CW'(1);
      end else if (state == GAP && gcnt != GW'(T_GAP)) gcnt <= gcnt + GW'(1);
      else if (any) begin
        state <= GRANT;
        gnt <= {{(N-1){1'b0}}, 1'b1} << pick;
        gnt_id <= pick;
        busy <= 1'b1;
        cnt <= CW'(1);
        ptr <= nxt;
      end else begin
        state <= IDLE;
        busy <= 1'b0;
      end
    end
endmodule

// File: tb/tb_timed_rr_arbiter.sv
// tb_timed_rr_arbiter: directed vectors push expected outputs into a
// scoreboard queue; a monitor pops and compares one entry per clock.
module tb_timed_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic busy, timeout;
  int total = 0;
  int passed = 0;

  typedef struct {
    logic [3:0] g;
    logic [1:0] id;
    logic b;
    logic t;
    string nm;
  } exp_t;
  exp_t q[$];

  timed_rr_arbiter #(.N(4), .T_MIN(2), .T_MAX(4), .T_GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (gnt === e.g && gnt_id === e.id && busy === e.b && timeout === e.t) passed++;
      else $display("FAIL %s: got gnt=%b id=%0d busy=%b to=%b, want gnt=%b id=%0d busy=%b to=%b",
                    e.nm, gnt, gnt_id, busy, timeout, e.g, e.id, e.b, e.t);
    end
  end

  task automatic step(input logic rn, input logic [3:0] r, input logic [3:0] g,
                      input logic [1:0] id, input logic b, input logic t, input string nm);
    exp_t e;
    @(posedge clk);
    #2;
    rst_n = rn;
    req = r;
    e.g = g; e.id = id; e.b = b; e.t = t; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [7:0] got);
    total++;
    if (got === 8'd0) passed++;
    else $display("FAIL %s: got %h, want 00", nm, got);
  endtask

  initial begin
    repeat (3) step(0, 4'b1111, 4'b0000, 0, 0, 0, "reset_hold");
    step(1, 4'b0000, 4'b0000, 0, 0, 0, "idle");
    step(1, 4'b0010, 4'b0010, 1, 1, 0, "minhold_g1");
    step(1, 4'b0000, 4'b0010, 1, 1, 0, "minhold_g2");
    step(1, 4'b0000, 4'b0000, 1, 1, 0, "minhold_gap");
    step(1, 4'b0000, 4'b0000, 1, 0, 0, "minhold_idle");
    repeat (2) begin
      repeat (4) step(1, 4'b0100, 4'b0100, 2, 1, 0, "tmo_grant");
      step(1, 4'b0100, 4'b0000, 2, 1, 1, "tmo_pulse");
    end
    step(1, 4'b0000, 4'b0000, 2, 0, 0, "tmo_idle");
    step(1, 4'b0100, 4'b0100, 2, 1, 0, "pre_async");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {gnt, gnt_id, busy, timeout});
    step(0, 4'b1111, 4'b0000, 0, 0, 0, "reset_low");
    for (int o = 0; o < 4; o++) begin
      repeat (4) step(1, 4'b1111, 4'(1 << o), 2'(o), 1, 0, "rr_grant");
      step(1, 4'b1111, 4'b0000, 2'(o), 1, 1, "rr_gap");
    end
    step(1, 4'b1111, 4'b0001, 0, 1, 0, "rr_wrap");
    step(1, 4'b0000, 4'b0001, 0, 1, 0, "rr_g2");
    step(1, 4'b0000, 4'b0000, 0, 1, 0, "rr_gap2");
    step(1, 4'b0000, 4'b0000, 0, 0, 0, "rr_idle");
    step(1, 4'b0100, 4'b0100, 2, 1, 0, "w_g2");
    step(1, 4'b0000, 4'b0100, 2, 1, 0, "w_g2b");
    step(1, 4'b0000, 4'b0000, 2, 1, 0, "w_gap");
    step(1, 4'b0000, 4'b0000, 2, 0, 0, "w_idle");
    repeat (4) step(1, 4'b0011, 4'b0001, 0, 1, 0, "w_wrap0");
    step(1, 4'b0011, 4'b0000, 0, 1, 1, "w_tmo");
    step(1, 4'b0011, 4'b0010, 1, 1, 0, "w_next1");
    step(1, 4'b0010, 4'b0010, 1, 1, 0, "rel_c2");
    step(1, 4'b0010, 4'b0010, 1, 1, 0, "rel_c3");
    step(1, 4'b0000, 4'b0000, 1, 1, 0, "rel_gap");
    step(1, 4'b0000, 4'b0000, 1, 0, 0, "rel_idle");
    step(1, 4'b1000, 4'b1000, 3, 1, 0, "col_c1");
    step(1, 4'b1000, 4'b1000, 3, 1, 0, "col_c2");
    step(1, 4'b1010, 4'b1000, 3, 1, 0, "col_other1");
    step(1, 4'b1001, 4'b1000, 3, 1, 0, "col_other2");
    step(1, 4'b0000, 4'b0000, 3, 1, 1, "col_tmo");
    step(1, 4'b0000, 4'b0000, 3, 0, 0, "col_idle");
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
